instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Sequential reader for the instruction memory. It walks a program counter over the 128-word memory, issues one read per cycle on the shared addr / write_enable / instructional_data interface, and buffers returned words in a 2-entry queue. The queue feeds the decode stage over a valid/ready handshake, and the block supports a start/stop address range and a branch redirect. It sits between instruction_memory and the decode stage, as the read-side counterpart to the memory-loading path.

## Interface
- ADDR_WIDTH, 7, word address width (128 words)
- DATA_WIDTH, 32, instruction width
- RESET_PC, 0, program counter value on reset
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin fetching; honoured only in IDLE
- start_addr  input  ADDR_WIDTH  first address fetched after start
- last_addr  input  ADDR_WIDTH  final address of the range, inclusive; sampled at each fetch
- redirect  input  1  branch redirect; flushes the queue
- redirect_addr  input  ADDR_WIDTH  new program counter on redirect
- addr  output  ADDR_WIDTH  memory word address, always equal to the program counter
- write_enable  output  1  memory write enable; constant 0
- instructional_data  inout  DATA_WIDTH  memory data bus; never driven (high-Z), only sampled
- instr  output  DATA_WIDTH  head-of-queue instruction
- instr_addr  output  ADDR_WIDTH  address of instr
- instr_valid  output  1  queue non-empty
- instr_ready  input  1  consumer accepts head when high with instr_valid
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse on the DRAIN→IDLE transition

## Operation
- Memory read is combinational: with write_enable=0, instructional_data equals mem[addr] in the same cycle.
- States are IDLE, RUN and DRAIN.
  - IDLE→RUN on start; pc is loaded with start_addr.
  - RUN→DRAIN when a fetch fires with pc==last_addr.
  - DRAIN→IDLE when the queue count is 0; done=1 for that one cycle.
- Pop: pop = instr_valid & instr_ready.
- Fetch condition: fetch = (state==RUN) & !redirect & !(count==2 & !pop).
  - On fetch, {instructional_data, pc} is written to the queue tail at the clock edge.
  - pc increments modulo 2^ADDR_WIDTH, so 127→0 wraps silently.
- Queue is a 2-entry FIFO with count in 0..2.
  - Simultaneous push and pop leaves count unchanged, with order preserved.
  - When full and pop is low, no fetch occurs and pc holds.
- Redirect, in RUN or DRAIN: the queue is cleared (count=0), pc<=redirect_addr, state<=RUN.
  - Redirect has priority over fetch and over the last_addr transition.
  - A pop in the same cycle counts as delivered.
  - Redirect in IDLE is ignored.
- start outside IDLE is ignored.
- last_addr earlier than start_addr in range order means fetching wraps through 127→0 until pc==last_addr.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, pc=RESET_PC, addr=RESET_PC.
  - count=0, instr_valid=0, instr=0, instr_addr=0.
  - busy=0, done=0, write_enable=0.
- Start latency: start sampled at edge E0; the first address is presented in the following cycle and captured at E1; instr_valid=1 after E1.
- Throughput is one instruction per cycle while instr_ready=1.
- Redirect latency: redirect sampled at edge R0 drives instr_valid=0 after R0. The target word is valid after R1.
- instr and instr_addr stay stable while instr_valid=1 and instr_ready=0.
- done is asserted in the cycle after the edge at which the final entry was popped. busy falls in the same cycle.
- Reset asserted mid-operation discards the queue and pc immediately. After release, the block waits in IDLE for start.

## Test plan
- Reset: hold reset_n=0 with no clock. Required: addr=0, write_enable=0, instr_valid=0, busy=0, done=0, instructional_data high-Z from this block.
- Full sweep: memory preloaded with mem[i]=128-i; start_addr=0, last_addr=127, instr_ready=1. Required: 128 consecutive beats, instr_addr 0..127 with instr 0x80 down to 0x01, first beat 2 edges after start, then one done pulse and busy=0.
- Backpressure: same preload with instr_ready=0 for 5 cycles after the first beat.
  - While stalled: queue holds addr 0 (0x80) and addr 1 (0x7F), and addr holds at 2.
  - On resume: beats 0,1,2,... with no loss or duplicate.
- Redirect: redirect=1 with redirect_addr=100 while the head is addr 10. Required: instr_valid=0 for one cycle, then addr 100 / 0x1C followed by 101 / 0x1B; entries 10–11 are never presented after the flush.
- Wrap: start_addr=126, last_addr=1. Required: beats in order (126, 0x02), (127, 0x01), (0, 0x80), (1, 0x7F), then done.
- Async reset mid-run: drop reset_n between clock edges during the sweep. Required: instr_valid, busy and addr reset immediately; after release, no fetch occurs until start.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - sequential instruction reader with a 2-entry output queue
// Walks pc from start_addr to last_addr inclusive, wrapping through the top of memory, with branch redirect.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  write_enable,
  inout  wire  [DATA_WIDTH-1:0] instructional_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic                  done_q, done_d;
  logic                  pop, fetch;

  always_comb begin
    pop     = (count_q != 2'd0) && instr_ready;
    fetch   = (state_q == RUN) && !redirect && !((count_q == 2'd2) && !pop);
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    data0_d = data0_q;
    data1_d = data1_q;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = start_addr;
        end
      end
      RUN, DRAIN: begin
        if (redirect) begin
          // Flush wins over fetch and the range-end check; a same-cycle pop is still delivered.
          state_d = RUN;
          pc_d    = redirect_addr;
          count_d = 2'd0;
        end else begin
          // Entry 0 is the head; a pop shifts entry 1 forward before the push lands.
          if (pop) begin
            data0_d = data1_q;
            addr0_d = addr1_q;
            count_d = count_q - 2'd1;
          end
          if (fetch) begin
            if (count_d == 2'd0) begin
              data0_d = instructional_data;
              addr0_d = pc_q;
            end else begin
              data1_d = instructional_data;
              addr1_d = pc_q;
            end
            count_d = count_d + 2'd1;
            pc_d    = pc_q + 1'b1;
            if (pc_q == last_addr) state_d = DRAIN;
          end
          if ((state_q == DRAIN) && (count_d == 2'd0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      data0_q <= '0;
      data1_q <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      done_q  <= done_d;
    end
  end

  assign addr         = pc_q;
  assign write_enable = 1'b0;
  assign instr        = data0_q;
  assign instr_addr   = addr0_q;
  assign instr_valid  = (count_q != 2'd0);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - bench for instruction_fetch against a queue-based behavioural model
// Directed scenarios with literal expectations plus randomized runs, all checked cycle by cycle.
module tb_instruction_fetch;

  typedef struct {
    logic [6:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  start_addr = '0;
  logic [6:0]  last_addr = '0;
  logic        redirect = 1'b0;
  logic [6:0]  redirect_addr = '0;
  logic [6:0]  addr;
  logic        write_enable;
  wire  [31:0] idata;
  logic [31:0] instr;
  logic [6:0]  instr_addr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [31:0] mem [128];
  assign idata = mem[addr];

  instruction_fetch #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .RESET_PC(7'd0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .last_addr(last_addr), .redirect(redirect), .redirect_addr(redirect_addr),
    .addr(addr), .write_enable(write_enable), .instructional_data(idata),
    .instr(instr), .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .done(done)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mst 0=idle 1=fetching 2=draining; the queue holds what decode will see.
  int         mst = 0;
  logic [6:0] mpc = '0;
  logic       mdone = 1'b0;
  ent_t       mq[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mst = 0; mpc = '0; mdone = 1'b0; mq.delete();
    end else if (mst == 0) begin
      mdone = 1'b0;
      if (start) begin mst = 1; mpc = start_addr; end
    end else if (redirect) begin
      mdone = 1'b0; mq.delete(); mpc = redirect_addr; mst = 1;
    end else begin
      bit delivered, blocked;
      delivered = (mq.size() > 0) && instr_ready;
      blocked   = (mq.size() == 2) && !delivered;
      if (delivered) void'(mq.pop_front());
      if (mst == 1 && !blocked) begin
        mq.push_back('{mpc, mem[mpc]});
        if (mpc == last_addr) mst = 2;
        mpc = mpc + 7'd1;
      end
      mdone = 1'b0;
      if (mst == 2 && mq.size() == 0) begin mst = 0; mdone = 1'b1; end
    end
  end

  ent_t beats[$];

  always @(negedge clk) begin
    chk("write_enable", 32'(write_enable), 32'd0);
    chk("addr", 32'(addr), 32'(mpc));
    chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
    chk("busy", 32'(busy), 32'(mst != 0));
    chk("done", 32'(done), 32'(mdone));
    if (mq.size() > 0) begin
      chk("instr", instr, mq[0].d);
      chk("instr_addr", 32'(instr_addr), 32'(mq[0].a));
    end
    if (done) chk("busy_at_done", 32'(busy), 32'd0);
    if (reset_n && instr_valid && instr_ready) beats.push_back('{instr_addr, instr});
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy && n < budget) begin step(1); n++; end
    chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic chk_beats(input string nm, input ent_t exp_b[$]);
    int bad = 0;
    chk({nm, "_count"}, 32'(beats.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < beats.size(); i++)
      if (beats[i].a !== exp_b[i].a || beats[i].d !== exp_b[i].d) bad++;
    chk({nm, "_order"}, 32'(bad), 32'd0);
  endtask

  task automatic kick(input logic [6:0] sa, input logic [6:0] la);
    start_addr = sa; last_addr = la; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  ent_t exp_b[$];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'(128 - i);

    #3;
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_write_enable", 32'(write_enable), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_addr", 32'(instr_addr), 32'd0);
    #4 reset_n = 1'b1;
    clk_en = 1'b1;
    step(2);

    // Full sweep with a two-edge start latency.
    beats.delete();
    instr_ready = 1'b1;
    kick(7'd0, 7'd127);
    chk("sweep_not_yet_valid", 32'(instr_valid), 32'd0);
    step(1);
    chk("sweep_first_valid", 32'(instr_valid), 32'd1);
    chk("sweep_first_addr", 32'(instr_addr), 32'd0);
    chk("sweep_first_instr", instr, 32'h80);
    wait_idle(300, "sweep_finish");
    exp_b.delete();
    for (int i = 0; i < 128; i++) exp_b.push_back('{7'(i), 32'(128 - i)});
    chk_beats("sweep", exp_b);

    // Backpressure: queue fills with addresses 0 and 1, pc parks at 2.
    step(2);
    beats.delete();
    instr_ready = 1'b0;
    kick(7'd0, 7'd20);
    step(1);
    step(5);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_head_addr", 32'(instr_addr), 32'd0);
    chk("stall_head_instr", instr, 32'h80);
    chk("stall_pc", 32'(addr), 32'd2);
    instr_ready = 1'b1;
    wait_idle(100, "stall_finish");
    exp_b.delete();
    for (int i = 0; i <= 20; i++) exp_b.push_back('{7'(i), 32'(128 - i)});
    chk_beats("stall", exp_b);

    // Redirect while address 10 is at the head.
    step(2);
    beats.delete();
    kick(7'd0, 7'd127);
    begin
      int n = 0;
      while (!(instr_valid && instr_addr == 7'd10) && n < 50) begin step(1); n++; end
      chk("redir_reach_10", 32'(instr_addr), 32'd10);
    end
    redirect = 1'b1; redirect_addr = 7'd100;
    step(1);
    redirect = 1'b0;
    chk("redir_flush_valid", 32'(instr_valid), 32'd0);
    step(1);
    chk("redir_target_addr", 32'(instr_addr), 32'd100);
    chk("redir_target_instr", instr, 32'h1C);
    step(1);
    chk("redir_next_addr", 32'(instr_addr), 32'd101);
    chk("redir_next_instr", instr, 32'h1B);
    wait_idle(100, "redir_finish");
    exp_b.delete();
    for (int i = 0; i <= 10; i++) exp_b.push_back('{7'(i), 32'(128 - i)});
    for (int i = 100; i <= 127; i++) exp_b.push_back('{7'(i), 32'(128 - i)});
    chk_beats("redir", exp_b);

    // Range wrapping through the top of memory.
    step(2);
    beats.delete();
    kick(7'd126, 7'd1);
    wait_idle(20, "wrap_finish");
    exp_b.delete();
    exp_b.push_back('{7'd126, 32'h02});
    exp_b.push_back('{7'd127, 32'h01});
    exp_b.push_back('{7'd0,   32'h80});
    exp_b.push_back('{7'd1,   32'h7F});
    chk_beats("wrap", exp_b);

    // Redirect while idle must be ignored (the per-cycle compare watches this).
    redirect = 1'b1; redirect_addr = 7'd55;
    step(1);
    redirect = 1'b0;
    step(2);

    // Randomized runs: random ranges, ready, redirects and stray starts.
    for (int r = 0; r < 8; r++) begin
      int n = 0;
      logic [6:0] sa;
      sa = 7'($urandom_range(0, 127));
      kick(sa, 7'(sa + 7'($urandom_range(0, 40))));
      while (busy && n < 200) begin
        instr_ready   = ($urandom_range(0, 9) < 7);
        redirect      = (n < 100) && ($urandom_range(0, 39) == 0);
        redirect_addr = 7'($urandom_range(0, 127));
        start         = ($urandom_range(0, 19) == 0);
        start_addr    = 7'($urandom_range(0, 127));
        step(1);
        n++;
      end
      start = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
      wait_idle(400, "rand_finish");
      step($urandom_range(1, 3));
    end

    // Asynchronous reset in the middle of a sweep.
    kick(7'd0, 7'd127);
    step(20);
    #2 reset_n = 1'b0;
    #1;
    chk("async_instr_valid", 32'(instr_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_addr", 32'(addr), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(5);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_valid", 32'(instr_valid), 32'd0);
    chk("post_reset_addr", 32'(addr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
